cache_request_scheduler: RTL

Credit-based round-robin scheduler that shares the single cache request channel between NUM_REQUESTORS memory requestors. It sits in front of the cache request path and grants at most one request per cycle into a registered output slot. It tracks outstanding requests per requestor and throttles any requestor that reaches its credit limit. A RUN/DRAIN/IDLE control state machine lets the control plane quiesce the channel before a reconfiguration.

---
 rtl/cache_request_scheduler_if.sv | 37 +++
 rtl/cache_request_scheduler.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/cache_request_scheduler_if.sv
// Request/response bundle shared between the cache request scheduler and
// its requestors, downstream cache port and control plane.
interface cache_request_scheduler_if #(
    parameter int NUM_REQUESTORS  = 4,
    parameter int ADDR_WIDTH      = 64,
    parameter int ID_WIDTH        = $clog2(NUM_REQUESTORS),
    parameter int MAX_OUTSTANDING = 16,
    parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
);
    logic                                sched_enable;
    logic [NUM_REQUESTORS-1:0]           req_valid;
    logic [NUM_REQUESTORS*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQUESTORS-1:0]           req_ready;
    logic                                out_valid;
    logic [ADDR_WIDTH-1:0]               out_addr;
    logic [ID_WIDTH-1:0]                 out_id;
    logic                                out_ready;
    logic                                resp_valid;
    logic [ID_WIDTH-1:0]                 resp_id;
    logic [NUM_REQUESTORS*CNT_WIDTH-1:0] outstanding_count;
    logic                                sched_idle;
    logic                                resp_error;

    // Scheduler side of the bundle.
    modport slave (
        input  sched_enable, req_valid, req_addr, out_ready, resp_valid, resp_id,
        output req_ready, out_valid, out_addr, out_id, outstanding_count,
               sched_idle, resp_error
    );

    // Requestor / downstream / control-plane side of the bundle.
    modport master (
        output sched_enable, req_valid, req_addr, out_ready, resp_valid, resp_id,
        input  req_ready, out_valid, out_addr, out_id, outstanding_count,
               sched_idle, resp_error
    );
endinterface

// File: rtl/cache_request_scheduler.sv
// Credit-based round-robin scheduler feeding one registered cache request
// slot from NUM_REQUESTORS requestors, with RUN/DRAIN/IDLE quiesce control.
module cache_request_scheduler #(
    parameter int NUM_REQUESTORS  = 4,
    parameter int ADDR_WIDTH      = 64,
    parameter int ID_WIDTH        = $clog2(NUM_REQUESTORS),
    parameter int MAX_OUTSTANDING = 16,
    parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    cache_request_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_stateNext;
    logic [CNT_WIDTH-1:0]    r_count [NUM_REQUESTORS];
    logic [ID_WIDTH-1:0]     r_lastGrant;
    logic                    r_outValid;
    logic [ADDR_WIDTH-1:0]   r_outAddr;
    logic [ID_WIDTH-1:0]     r_outId;
    logic                    r_idle;
    logic                    r_respError;

    logic                    w_slotFree;
    logic                    w_allZero;
    logic                    w_respBad;
    logic                    w_grantValid;
    logic [ID_WIDTH-1:0]     w_grantId;
    logic [NUM_REQUESTORS-1:0] w_eligible;
    logic [NUM_REQUESTORS-1:0] w_grant;
    logic [NUM_REQUESTORS-1:0] w_respHit;
    logic [NUM_REQUESTORS*CNT_WIDTH-1:0] w_countFlat;

    // Maps a rotated search position back onto a requestor index.
    function automatic logic [ID_WIDTH-1:0] wrapIdx(input int value);
        wrapIdx = ID_WIDTH'(value % NUM_REQUESTORS);
    endfunction

    // Per-requestor eligibility, response matching and counter flattening.
    always_comb begin
        w_slotFree  = ~r_outValid | bus.out_ready;
        w_allZero   = 1'b1;
        w_eligible  = '0;
        w_respHit   = '0;
        w_countFlat = '0;
        for (int i = 0; i < NUM_REQUESTORS; i++) begin
            w_eligible[i] = bus.req_valid[i] && (r_count[i] < CNT_WIDTH'(MAX_OUTSTANDING))
                            && (r_state == ST_RUN) && w_slotFree;
            w_respHit[i]  = bus.resp_valid && (bus.resp_id == ID_WIDTH'(i)) && (r_count[i] != '0);
            if (r_count[i] != '0) begin
                w_allZero = 1'b0;
            end
            w_countFlat[i*CNT_WIDTH +: CNT_WIDTH] = r_count[i];
        end
        w_respBad = bus.resp_valid && (w_respHit == '0);
    end

    // Round-robin pick starting just after the last granted requestor.
    always_comb begin
        w_grantValid = 1'b0;
        w_grantId    = '0;
        w_grant      = '0;
        for (int k = 0; k < NUM_REQUESTORS; k++) begin
            if (!w_grantValid && w_eligible[wrapIdx(int'(r_lastGrant) + 1 + k)]) begin
                w_grantValid = 1'b1;
                w_grantId    = wrapIdx(int'(r_lastGrant) + 1 + k);
            end
        end
        for (int i = 0; i < NUM_REQUESTORS; i++) begin
            w_grant[i] = w_grantValid && (w_grantId == ID_WIDTH'(i));
        end
    end

    // Control state machine next-state logic.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE:  if (bus.sched_enable) w_stateNext = ST_RUN;
            ST_RUN:   if (!bus.sched_enable) w_stateNext = ST_DRAIN;
            ST_DRAIN: begin
                if (bus.sched_enable) begin
                    w_stateNext = ST_RUN;
                end else if (w_allZero && !r_outValid) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default:  w_stateNext = ST_IDLE;
        endcase
    end

    // State register plus registered idle and sticky error flags.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state     <= ST_IDLE;
            r_idle      <= 1'b1;
            r_respError <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_idle      <= (r_state == ST_IDLE) && w_allZero && !r_outValid;
            r_respError <= r_respError | w_respBad;
        end
    end

    // Output slot and round-robin pointer; the slot holds under backpressure.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_outValid  <= 1'b0;
            r_outAddr   <= '0;
            r_outId     <= '0;
            r_lastGrant <= ID_WIDTH'(NUM_REQUESTORS - 1);
        end else if (w_grantValid) begin
            r_outValid  <= 1'b1;
            r_outAddr   <= bus.req_addr[int'(w_grantId)*ADDR_WIDTH +: ADDR_WIDTH];
            r_outId     <= w_grantId;
            r_lastGrant <= w_grantId;
        end else if (r_outValid && bus.out_ready) begin
            r_outValid  <= 1'b0;
        end
    end

    // Outstanding credit counters; a grant and a response in one cycle cancel.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < NUM_REQUESTORS; i++) begin
                r_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQUESTORS; i++) begin
                if (w_grant[i] && !w_respHit[i]) begin
                    r_count[i] <= r_count[i] + 1'b1;
                end else if (!w_grant[i] && w_respHit[i]) begin
                    r_count[i] <= r_count[i] - 1'b1;
                end
            end
        end
    end

    assign bus.req_ready         = w_grant;
    assign bus.out_valid         = r_outValid;
    assign bus.out_addr          = r_outAddr;
    assign bus.out_id            = r_outId;
    assign bus.outstanding_count = w_countFlat;
    assign bus.sched_idle        = r_idle;
    assign bus.resp_error        = r_respError;

endmodule
